// File: rtl/tick_period_meter_if.sv
// Interface bundle for tick_period_meter: tick/clear request side and measurement results.
interface tick_period_meter_if #(
    parameter int unsigned COUNT_BITS = 16
);
    logic                  tick_in;
    logic                  clear;
    logic [COUNT_BITS-1:0] period;
    logic                  period_valid;
    logic [COUNT_BITS-1:0] period_min;
    logic [COUNT_BITS-1:0] period_max;
    logic                  timeout;
    logic                  locked;

    modport master (
        output tick_in,
        output clear,
        input  period,
        input  period_valid,
        input  period_min,
        input  period_max,
        input  timeout,
        input  locked
    );

    modport slave (
        input  tick_in,
        input  clear,
        output period,
        output period_valid,
        output period_min,
        output period_max,
        output timeout,
        output locked
    );
endinterface

// File: rtl/tick_period_meter.sv
// Measures clk-cycle spacing between rising edges of tick_in, tracks min/max
// and flags a stalled tick source.
module tick_period_meter #(
    parameter int unsigned COUNT_BITS     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    tick_period_meter_if.slave bus
);

    localparam logic [COUNT_BITS-1:0] TIMEOUT_CNT = COUNT_BITS'(TIMEOUT_CYCLES);
    localparam logic [COUNT_BITS-1:0] CNT_ONE     = COUNT_BITS'(1);
    localparam logic [COUNT_BITS-1:0] CNT_ZERO    = '0;
    localparam logic [COUNT_BITS-1:0] CNT_ONES    = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

    state_e                state_q,   state_d;
    logic                  tick_prev_q, tick_prev_d;
    logic [COUNT_BITS-1:0] count_q,   count_d;
    logic [COUNT_BITS-1:0] period_q,  period_d;
    logic                  valid_q,   valid_d;
    logic [COUNT_BITS-1:0] min_q,     min_d;
    logic [COUNT_BITS-1:0] max_q,     max_d;
    logic                  timeout_q, timeout_d;
    logic                  locked_q,  locked_d;
    logic                  edge_c;

    assign edge_c = bus.tick_in & ~tick_prev_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tick_prev_q <= 1'b0;
            count_q     <= CNT_ZERO;
            period_q    <= CNT_ZERO;
            valid_q     <= 1'b0;
            min_q       <= CNT_ONES;
            max_q       <= CNT_ZERO;
            timeout_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_prev_q <= tick_prev_d;
            count_q     <= count_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            min_q       <= min_d;
            max_q       <= max_d;
            timeout_q   <= timeout_d;
            locked_q    <= locked_d;
        end
    end

    // Next-state: clear dominates; an edge at count==TIMEOUT still counts as a measurement
    always_comb begin
        state_d     = state_q;
        tick_prev_d = bus.tick_in;
        count_d     = count_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        min_d       = min_q;
        max_d       = max_q;
        timeout_d   = timeout_q;
        locked_d    = locked_q;

        if (bus.clear) begin
            state_d   = ST_IDLE;
            count_d   = CNT_ZERO;
            min_d     = CNT_ONES;
            max_d     = CNT_ZERO;
            timeout_d = 1'b0;
            locked_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    count_d = CNT_ZERO;
                    if (edge_c) begin
                        state_d = ST_ARMED;
                        count_d = CNT_ONE;
                    end
                end
                ST_ARMED, ST_MEASURE: begin
                    if (edge_c) begin
                        state_d  = ST_MEASURE;
                        period_d = count_q;
                        valid_d  = 1'b1;
                        min_d    = (count_q < min_q) ? count_q : min_q;
                        max_d    = (count_q > max_q) ? count_q : max_q;
                        count_d  = CNT_ONE;
                        locked_d = 1'b1;
                    end else if (count_q == TIMEOUT_CNT) begin
                        state_d   = ST_IDLE;
                        count_d   = CNT_ZERO;
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = CNT_ZERO;
                end
            endcase
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = valid_q;
    assign bus.period_min   = min_q;
    assign bus.period_max   = max_q;
    assign bus.timeout      = timeout_q;
    assign bus.locked       = locked_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: directed scenarios plus random tick trains,
// checked every cycle against a timestamp-based reference model.
module tb_tick_period_meter;

    localparam int unsigned CB   = 12;
    localparam int unsigned TO   = 1300;
    localparam int unsigned ONES = (1 << CB) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tick_period_meter_if #(.COUNT_BITS(CB)) bus ();

    tick_period_meter #(
        .COUNT_BITS    (CB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: remembers the timestamp of the last accepted edge
    longint      t_now  = 0;
    longint      last_t = 0;
    bit          m_armed, m_prev, m_valid, m_timeout, m_locked;
    int unsigned m_period, m_min, m_max;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_armed   = 1'b0;
        m_prev    = 1'b0;
        m_valid   = 1'b0;
        m_timeout = 1'b0;
        m_locked  = 1'b0;
        m_period  = 0;
        m_min     = ONES;
        m_max     = 0;
    endfunction

    function automatic void model_step(input bit tk, input bit clr);
        bit     rise;
        longint el;
        rise    = tk && !m_prev;
        m_valid = 1'b0;
        if (clr) begin
            m_armed   = 1'b0;
            m_locked  = 1'b0;
            m_timeout = 1'b0;
            m_min     = ONES;
            m_max     = 0;
        end else if (m_armed) begin
            el = t_now - last_t;
            if (rise) begin
                m_period = int'(el);
                m_valid  = 1'b1;
                if (m_period < m_min) m_min = m_period;
                if (m_period > m_max) m_max = m_period;
                m_locked = 1'b1;
                last_t   = t_now;
            end else if (el == longint'(TO)) begin
                m_timeout = 1'b1;
                m_locked  = 1'b0;
                m_armed   = 1'b0;
            end
        end else if (rise) begin
            m_armed = 1'b1;
            last_t  = t_now;
        end
        m_prev = tk;
        t_now++;
    endfunction

    task automatic check_all();
        check("period",  32'(bus.period),       32'(m_period));
        check("valid",   32'(bus.period_valid), 32'(m_valid));
        check("min",     32'(bus.period_min),   32'(m_min));
        check("max",     32'(bus.period_max),   32'(m_max));
        check("timeout", 32'(bus.timeout),      32'(m_timeout));
        check("locked",  32'(bus.locked),       32'(m_locked));
    endtask

    // One clock: drive at negedge, model after posedge, compare at next negedge
    task automatic cyc(input bit tk, input bit clr);
        if (n_mis >= 40) return;
        bus.tick_in = tk;
        bus.clear   = clr;
        @(posedge clk);
        model_step(tk, clr);
        @(negedge clk);
        check_all();
    endtask

    // Rise now, high for width cycles, low for the rest; successive calls space rises by gap
    task automatic train(input int gap, input int width, input bit rnd_clear);
        for (int i = 0; i < gap; i++)
            cyc(i < width, rnd_clear && ($urandom_range(0, 499) == 0));
    endtask

    // Asynchronous reset between clock edges, checked before any edge arrives
    task automatic async_reset();
        bus.tick_in = 1'b0;
        bus.clear   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int gap;
        int op;
        bus.tick_in = 1'b0;
        bus.clear   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0);

        // Steady 1251-cycle tick train, five pulses
        repeat (5) train(1251, 1, 1'b0);
        check("p1251",   32'(bus.period),     32'd1251);
        check("min1251", 32'(bus.period_min), 32'd1251);
        check("max1251", 32'(bus.period_max), 32'd1251);
        check("lock1251", 32'(bus.locked),    32'd1);

        // Spacings 100, 40, 300
        cyc(1'b0, 1'b1);
        train(100, 1, 1'b0);
        train(40, 1, 1'b0);
        train(300, 1, 1'b0);
        train(5, 1, 1'b0);
        check("seq_min", 32'(bus.period_min), 32'd40);
        check("seq_max", 32'(bus.period_max), 32'd300);

        // Stall detection, recovery with timeout still sticky, then clear
        cyc(1'b0, 1'b1);
        train(TO + 5, 1, 1'b0);
        check("stall_to",   32'(bus.timeout), 32'd1);
        check("stall_lock", 32'(bus.locked),  32'd0);
        train(20, 1, 1'b0);
        train(3, 1, 1'b0);
        check("rec_period", 32'(bus.period),  32'd20);
        check("rec_to",     32'(bus.timeout), 32'd1);
        cyc(1'b0, 1'b1);
        check("clr_to",     32'(bus.timeout), 32'd0);

        // Edge landing exactly on the timeout count
        train(TO, 1, 1'b0);
        train(TO, 1, 1'b0);
        train(3, 1, 1'b0);
        check("edge_to_p",  32'(bus.period),  32'(TO));
        check("edge_to_to", 32'(bus.timeout), 32'd0);

        // clear coinciding with an edge discards that edge
        train(30, 1, 1'b0);
        cyc(1'b1, 1'b1);
        repeat (29) cyc(1'b0, 1'b0);
        train(30, 1, 1'b0);
        train(30, 1, 1'b0);
        check("clr_edge_p",   32'(bus.period),     32'd30);
        check("clr_edge_min", 32'(bus.period_min), 32'd30);
        check("clr_edge_max", 32'(bus.period_max), 32'd30);

        // Level held high counts as one edge
        cyc(1'b0, 1'b1);
        train(200, 10, 1'b0);
        train(5, 1, 1'b0);
        check("level_p", 32'(bus.period), 32'd200);

        // Reset in the middle of an interval
        train(60, 1, 1'b0);
        train(50, 1, 1'b0);
        async_reset();
        repeat (2) cyc(1'b0, 1'b0);

        // Randomised tick trains with occasional clear and reset
        repeat (60) begin
            op = int'($urandom_range(0, 19));
            if (op == 0) begin
                cyc(1'b0, 1'b1);
            end else if (op == 1) begin
                async_reset();
            end else begin
                gap = int'($urandom_range(2, TO + 60));
                train(gap, int'($urandom_range(1, gap - 1)), 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
